// File: rtl/uart_pkg.sv
// Shared frame layout and error bundle for the UART receive deframer.
// Bit positions match the raw 12-bit frame produced by uart_rx.
package uart_pkg;

  localparam int FRAME_W   = 12;
  localparam int STOP_BIT  = 11;
  localparam int DATA_MSB  = 10;
  localparam int DATA_LSB  = 3;
  localparam int PAR_BIT   = 2;
  localparam int START_BIT = 1;

  typedef struct packed {
    logic overflow;
    logic framing;
    logic parity;
  } uart_err_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrapping pointers and a separate occupancy count.
// The head is masked to zero while empty so the output is clean after reset.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd      = rd_en && !empty;
  assign wr      = wr_en && (!full || rd);
  assign rd_data = empty ? '0 : mem[rptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks net push/pop.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      if (wr && !rd)
        count <= count + CW'(1);
      else if (rd && !wr)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Checks raw uart_rx frames, queues good bytes, keeps sticky error flags.
// Parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PARITY_ODD = 0,
  parameter int DROP_BAD   = 1,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [FRAME_W-1:0] frame,
  input  logic               frame_valid,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic               framing_err,
  output logic               parity_err,
  input  logic               clear_err
);

  logic      bad_frame;
  logic      bad_par;
  logic      store;
  logic      pop;
  logic      empty;
  logic      full;
  uart_err_t err;
  uart_err_t hit;
  logic      unused_bits;

  assign bad_frame = frame[START_BIT] || !frame[STOP_BIT];

`ifdef UART_RX_PARITY_EN
  assign bad_par = (^frame[DATA_MSB:PAR_BIT]) != 1'(PARITY_ODD);
  assign unused_bits = frame[0];
`else
  assign bad_par = 1'b0;
  assign unused_bits = ^{frame[0], frame[PAR_BIT], 1'(PARITY_ODD)};
`endif

  assign store = frame_valid &&
                 (!(bad_frame || bad_par) || DROP_BAD == 0);
  assign pop   = m_valid && m_ready;

  uart_sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .nreset  (nreset),
    .wr_en   (store),
    .wr_data (frame[DATA_MSB:DATA_LSB]),
    .rd_en   (pop),
    .rd_data (m_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign m_valid = !empty;

  // Events that raise a sticky flag this cycle.
  always_comb begin
    hit          = '0;
    hit.overflow = store && full && !pop;
    hit.framing  = frame_valid && bad_frame;
    hit.parity   = frame_valid && bad_par;
  end

  // Sticky flags; a new event beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!nreset)
      err <= '0;
    else if (clear_err)
      err <= hit;
    else
      err <= err | hit;
  end

  assign overflow    = err.overflow;
  assign framing_err = err.framing;
  assign parity_err  = err.parity;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer (DEPTH=16).
// Expectations adapt to whether UART_RX_PARITY_EN is defined.
module tb_uart_rx_deframer;

  logic        clock = 1'b0;
  logic        nreset;
  logic [11:0] frame;
  logic        frame_valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  count;
  logic        overflow;
  logic        framing_err;
  logic        parity_err;
  logic        clear_err;

  int passed = 0;
  int total  = 0;
  logic [7:0] q[$];

  uart_rx_deframer #(
    .DEPTH      (16),
    .PARITY_ODD (0),
    .DROP_BAD   (1)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .frame       (frame),
    .frame_valid (frame_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .count       (count),
    .overflow    (overflow),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .clear_err   (clear_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] mk(input logic [7:0] b);
    return {1'b1, b, ^b, 1'b0, 1'b1};
  endfunction

  task automatic strobe(input logic [11:0] f);
    frame       = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  initial begin
    nreset      = 1'b0;
    frame       = '0;
    frame_valid = 1'b0;
    m_ready     = 1'b0;
    clear_err   = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_flags",
        32'({overflow, framing_err, parity_err}), 0);

    strobe(12'hC05);
    chk("good_valid", 32'(m_valid), 1);
    chk("good_data", 32'(m_data), 32'h80);
    chk("good_count", 32'(count), 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("pop_valid", 32'(m_valid), 0);
    chk("pop_count", 32'(count), 0);

    strobe(12'h405);
    chk("stop_ferr", 32'(framing_err), 1);
    chk("stop_count", 32'(count), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_ferr", 32'(framing_err), 0);

    strobe(12'hC01);
`ifdef UART_RX_PARITY_EN
    chk("par_perr", 32'(parity_err), 1);
    chk("par_count", 32'(count), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("par_clr", 32'(parity_err), 0);
`else
    chk("par_perr", 32'(parity_err), 0);
    chk("par_count", 32'(count), 1);
    chk("par_data", 32'(m_data), 32'h80);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("par_drain", 32'(count), 0);
`endif

    frame     = 12'h405;
    frame_valid = 1'b1;
    clear_err = 1'b1;
    tick();
    frame_valid = 1'b0;
    clear_err = 1'b0;
    chk("set_wins", 32'(framing_err), 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("set_wins_clr", 32'(framing_err), 0);

    for (int i = 0; i < 17; i++) begin
      frame       = mk(8'(i));
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    chk("full_count", 32'(count), 16);
    chk("full_ovf", 32'(overflow), 1);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 1'b0;
    chk("drain_valid", 32'(m_valid), 0);
    chk("drain_count", 32'(count), 0);

    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    for (int i = 0; i < 16; i++) begin
      frame       = mk(8'(100 + i));
      frame_valid = 1'b1;
      q.push_back(8'(100 + i));
      tick();
    end
    chk("refill_count", 32'(count), 16);
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      frame = mk(8'(200 + i));
      chk($sformatf("b2b_head%0d", i), 32'(m_data), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(8'(200 + i));
      tick();
      chk($sformatf("b2b_cnt%0d", i), 32'(count), 16);
    end
    frame_valid = 1'b0;
    chk("b2b_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tail%0d", i), 32'(m_data), 32'(q[0]));
      void'(q.pop_front());
      tick();
    end
    m_ready = 1'b0;
    chk("tail_empty", 32'(m_valid), 0);

    for (int i = 0; i < 5; i++) begin
      frame       = mk(8'(i + 1));
      frame_valid = 1'b1;
      tick();
    end
    frame_valid = 1'b0;
    strobe(12'h405);
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_ferr", 32'(framing_err), 1);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_data", 32'(m_data), 0);
    chk("mid_rst_flags",
        32'({overflow, framing_err, parity_err}), 0);

    strobe(mk(8'h5A));
    chk("post_rst_data", 32'(m_data), 32'h5A);
    chk("post_rst_count", 32'(count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
